// File: rtl/splt_drop_fifo_pkg.sv
// splt_drop_fifo_pkg: shared types and sizing for the store-and-forward drop FIFO
package splt_drop_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_DROP
  } wr_state_e;

  // One stored beat is {tlast, tuser, tkeep, tdata}.
  function automatic int entry_w(input int dw, input int uw);
    return dw + dw / 8 + uw + 1;
  endfunction

  localparam int ENTRY_W = entry_w(256, 256);

endpackage

// File: rtl/splt_fifo_ram.sv
// splt_fifo_ram: simple dual-port beat store, synchronous write, asynchronous read
module splt_fifo_ram
  import splt_drop_fifo_pkg::*;
#(
  parameter int AW = 6,
  parameter int W  = ENTRY_W
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];

  // Storage is not reset; only committed entries are ever observed.
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/splt_drop_fifo.sv
// splt_drop_fifo: never-stalling packet FIFO that forwards whole packets and drops overflowing ones
module splt_drop_fifo
  import splt_drop_fifo_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 256,
  parameter int DEPTH_BITS         = 6,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  input  logic                            cnt_clear,
  output logic [CNT_WIDTH-1:0]            pkt_in_cnt,
  output logic [CNT_WIDTH-1:0]            pkt_out_cnt,
  output logic [CNT_WIDTH-1:0]            pkt_drop_cnt
);

  localparam int EW = entry_w(C_AXIS_DATA_WIDTH, C_AXIS_TUSER_WIDTH);
  localparam int PW = DEPTH_BITS + 1;
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {DEPTH_BITS{1'b0}}};

  wr_state_e            state_q, state_d;
  logic [PW-1:0]        wr_q, wr_d, commit_q, commit_d, rd_q;
  logic [CNT_WIDTH-1:0] in_q, out_q, drop_q;
  logic                 full, we, in_inc, drop_inc, pop;
  logic [EW-1:0]        rd_entry;

  assign full          = (wr_q - rd_q) == DEPTH_P;
  assign we            = s_axis_tvalid && !full && state_q != ST_DROP;
  assign in_inc        = s_axis_tvalid && state_q == ST_IDLE;
  assign m_axis_tvalid = rd_q != commit_q;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign s_axis_tready = 1'b1;
  assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = m_axis_tvalid ? rd_entry : '0;
  assign pkt_in_cnt    = in_q;
  assign pkt_out_cnt   = out_q;
  assign pkt_drop_cnt  = drop_q;

  splt_fifo_ram #(.AW(DEPTH_BITS), .W(EW)) u_ram (
    .clk_i   (axis_aclk),
    .we_i    (we),
    .waddr_i (wr_q[DEPTH_BITS-1:0]),
    .wdata_i ({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata}),
    .raddr_i (rd_q[DEPTH_BITS-1:0]),
    .rdata_o (rd_entry)
  );

  // Write FSM; IDLE and ACCEPT share handling because wr equals commit while IDLE.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    commit_d = commit_q;
    drop_inc = 1'b0;
    if (s_axis_tvalid)
      case (state_q)
        ST_IDLE, ST_ACCEPT:
          if (!full) begin
            wr_d    = wr_q + PW'(1);
            state_d = s_axis_tlast ? ST_IDLE : ST_ACCEPT;
            if (s_axis_tlast) commit_d = wr_q + PW'(1);
          end else begin
            wr_d     = commit_q;
            drop_inc = 1'b1;
            state_d  = s_axis_tlast ? ST_IDLE : ST_DROP;
          end
        default: state_d = s_axis_tlast ? ST_IDLE : ST_DROP;
      endcase
  end

  // Pointer, state and counter registers; clear beats a coincident increment.
  always_ff @(posedge axis_aclk or negedge axis_resetn)
    if (!axis_resetn) begin
      state_q  <= ST_IDLE;
      wr_q     <= '0;
      commit_q <= '0;
      rd_q     <= '0;
      in_q     <= '0;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      commit_q <= commit_d;
      rd_q     <= rd_q + PW'(pop);
      in_q     <= cnt_clear ? '0 : in_q + CNT_WIDTH'(in_inc);
      out_q    <= cnt_clear ? '0 : out_q + CNT_WIDTH'(pop && m_axis_tlast);
      drop_q   <= cnt_clear ? '0 : drop_q + CNT_WIDTH'(drop_inc);
    end

endmodule

// File: doc/splt_drop_fifo.md
# splt_drop_fifo

Store-and-forward packet FIFO on the 256-bit-tuser branch (`m_axis_1_*`) of the stream splitter. It always accepts beats (`s_axis_tready` tied high), so this branch can never stall the splitter. Only complete packets are forwarded. A packet that overflows storage is dropped whole and counted. Per-packet in/out/drop counters feed the splitter's CPU register block.

## Interface
Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width; tkeep is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 256, tuser width; passed through unmodified.
- DEPTH_BITS, 6, storage depth = 2^DEPTH_BITS beats.
- CNT_WIDTH, 32, counter width.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_resetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  input data from splitter branch 1.
- s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  byte enables.
- s_axis_tuser  in  C_AXIS_TUSER_WIDTH  metadata.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  constant 1.
- s_axis_tlast  in  1  end of packet.
- m_axis_tdata / m_axis_tkeep / m_axis_tuser  out  same widths  stored beat at read pointer.
- m_axis_tvalid  out  1  committed beat available.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  stored tlast.
- cnt_clear  in  1  synchronous pulse; zeroes all counters.
- pkt_in_cnt  out  CNT_WIDTH  packets whose first beat was seen.
- pkt_out_cnt  out  CNT_WIDTH  packets fully emitted (tlast beat popped).
- pkt_drop_cnt  out  CNT_WIDTH  packets discarded for overflow.

## Operation
- Pointers are DEPTH_BITS+1 bits wide; the MSB is the wrap bit. There are three of them:
  - wr_ptr: speculative write position.
  - commit_ptr: end of the last complete packet.
  - rd_ptr: read position.
- full is (wr_ptr − rd_ptr) == 2^DEPTH_BITS. All pointer arithmetic is modulo 2^(DEPTH_BITS+1).
- The write FSM has states IDLE (expecting SOP), ACCEPT and DROP.
  - IDLE, beat arrives: pkt_in_cnt increments.
    - If not full: write the beat. On tlast, commit and stay in IDLE; otherwise go to ACCEPT.
    - If full: go to DROP and increment pkt_drop_cnt. If that beat also carries tlast, stay in IDLE instead of entering DROP.
  - ACCEPT, beat arrives:
    - If not full: write it. On tlast, set commit_ptr to wr_ptr+1 and return to IDLE.
    - If full: set wr_ptr back to commit_ptr and increment pkt_drop_cnt. Go to DROP, or to IDLE if the beat carries tlast.
  - DROP: discard beats; return to IDLE on tlast.
- Read side:
  - m_axis_tvalid = (rd_ptr != commit_ptr).
  - Outputs show the entry at rd_ptr.
  - A pop occurs on tvalid & tready and increments rd_ptr.
  - A popped tlast increments pkt_out_cnt.
- Read and write proceed in the same cycle independently. full is evaluated against the registered rd_ptr, so a slot freed this cycle is usable next cycle.
- Counters wrap modulo 2^CNT_WIDTH. If cnt_clear coincides with an increment, clear wins and the counter becomes 0.
- Reset values:
  - All pointers 0, FSM IDLE, all counters 0.
  - m_axis_tvalid 0; m_axis_tdata, m_axis_tkeep, m_axis_tuser and m_axis_tlast 0 (storage contents are don't-care).
  - s_axis_tready 1.
- Reset mid-packet discards all stored and partial data. The first beat after reset is treated as an SOP.

## Timing
- Latency: the first beat of a packet appears on m_axis the cycle after its tlast beat is written, given an empty FIFO.
- Throughput is 1 beat/cycle on each side.
- A packet of exactly 2^DEPTH_BITS beats into an empty FIFO is accepted. One more beat than that is dropped.
- Output obeys AXI-Stream: once tvalid is asserted, tdata/tkeep/tuser/tlast stay stable until tready.
- A drop rollback never moves commit_ptr or rd_ptr, so committed packets are unaffected.

## Structure
- Package splt_drop_fifo_pkg holds:
  - the FSM state enum (IDLE, ACCEPT, DROP);
  - the entry width constant ENTRY_W = data + keep + tuser + 1.
- Sub-module splt_fifo_ram: 2^DEPTH_BITS × ENTRY_W simple dual-port array with a synchronous write port and an asynchronous read port.

## Test plan
- Single packet: a 3-beat packet into an empty FIFO with tready=1.
  - m_axis_tvalid rises on the cycle after the tlast write.
  - The 3 beats come out in order with identical tuser.
  - pkt_in=1, pkt_out=1, drop=0.
- One-beat packets: 64 back-to-back packets with tready=0 fill the FIFO. Then a 1-beat packet arrives.
  - The extra packet is dropped; drop=1.
  - Raise tready: exactly 64 packets drain; pkt_out=64.
- Mid-packet overflow: an empty FIFO with tready=0 holds a committed 60-beat packet. Then a 10-beat packet arrives.
  - The second packet rolls back at beat 5 and is dropped; drop=1.
  - The output drains exactly 60 beats, with tlast on beat 60.
- Continuous flow: simultaneous streaming with tready=1 and 1000 random-length packets (1–64 beats).
  - No drops.
  - The output stream is bit-identical to the input; pkt_in=pkt_out=1000.
- Clear collision: assert cnt_clear in the same cycle as a popped tlast → pkt_out_cnt=0.
- Async reset: assert axis_resetn=0 mid-packet.
  - m_axis_tvalid drops immediately and all counters go to 0.
  - After release, a 2-beat packet is forwarded intact.
